// File: rtl/pipelined_barrel_shifter_if.sv
// Request/response bundle for the pipelined barrel shifter.
// The master drives requests and accepts results; the slave is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_illegal;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_illegal
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_illegal
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Two-stage ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out.
// All shifts run as right shifts; LSL reverses the operand before and after.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int LOG = $clog2(WIDTH);
  localparam int LO  = LOG / 2;
  localparam logic [31:0]    W_U = WIDTH;
  localparam logic [LOG-1:0] ONE = 1;

  logic [LOG-1:0]   m, lsl_idx, rsh_idx, amt_d;
  logic             n_zero, n_eq_w, n_gt_w;
  logic [WIDTH-1:0] data_rev, base_d, out_rev, s2_result;
  logic             rev_d, rot_d, fill_d, carry_d, illegal_d;
  logic [WIDTH-1:0] chain [0:LOG];

  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s1_data_q;
  logic [LOG-1:LO]  s1_amt_q;
  logic             s1_rev_q, s1_rot_q, s1_fill_q, s1_carry_q, s1_illegal_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_carry_q, out_illegal_q;
  logic             s2_free, in_ready, in_fire;

  assign m       = bus.in_amt[LOG-1:0];
  assign lsl_idx = -m;
  assign rsh_idx = m - ONE;
  assign n_zero  = (bus.in_amt == '0);
  assign n_eq_w  = (32'(bus.in_amt) == W_U);
  assign n_gt_w  = (32'(bus.in_amt) >  W_U);

  // Out-of-range amounts are folded into the base operand so the shift network only sees m < WIDTH.
  always_comb begin
    rev_d     = 1'b0;
    rot_d     = 1'b0;
    fill_d    = 1'b0;
    base_d    = bus.in_data;
    amt_d     = m;
    carry_d   = bus.in_carry;
    illegal_d = 1'b0;
    case (bus.in_op)
      3'b000: begin
        rev_d  = 1'b1;
        base_d = data_rev;
        if (n_gt_w) begin
          base_d = '0; amt_d = '0; carry_d = 1'b0;
        end else if (n_eq_w) begin
          base_d = '0; amt_d = '0; carry_d = bus.in_data[0];
        end else if (!n_zero) begin
          carry_d = bus.in_data[lsl_idx];
        end
      end
      3'b001: begin
        if (n_gt_w) begin
          base_d = '0; amt_d = '0; carry_d = 1'b0;
        end else if (n_eq_w) begin
          base_d = '0; amt_d = '0; carry_d = bus.in_data[WIDTH-1];
        end else if (!n_zero) begin
          carry_d = bus.in_data[rsh_idx];
        end
      end
      3'b010: begin
        fill_d = bus.in_data[WIDTH-1];
        if (n_gt_w || n_eq_w) begin
          base_d  = {WIDTH{bus.in_data[WIDTH-1]}};
          amt_d   = '0;
          carry_d = bus.in_data[WIDTH-1];
        end else if (!n_zero) begin
          carry_d = bus.in_data[rsh_idx];
        end
      end
      3'b011: begin
        rot_d = 1'b1;
        // m==0 with n!=0 wraps rsh_idx to WIDTH-1, which is exactly the required carry.
        if (!n_zero) carry_d = bus.in_data[rsh_idx];
      end
      3'b100: begin
        base_d  = {bus.in_carry, bus.in_data[WIDTH-1:1]};
        amt_d   = '0;
        carry_d = bus.in_data[0];
      end
      default: begin
        amt_d     = '0;
        illegal_d = 1'b1;
      end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign data_rev[gi] = bus.in_data[WIDTH-1-gi];
    assign out_rev[gi]  = chain[LOG][WIDTH-1-gi];
  end

  // Levels below LO belong to stage 1; level LO restarts from the stage-1 register.
  assign chain[0] = base_d;
  for (genvar gi = 0; gi < LOG; gi++) begin : g_lvl
    localparam int S = 1 << gi;
    logic [WIDTH-1:0] lvl_src;
    logic             lvl_sel, lvl_rot, lvl_fill;
    if (gi == LO) begin : g_src_reg
      assign lvl_src = s1_data_q;
    end else begin : g_src_chain
      assign lvl_src = chain[gi];
    end
    if (gi < LO) begin : g_ctl_s1
      assign lvl_sel  = amt_d[gi];
      assign lvl_rot  = rot_d;
      assign lvl_fill = fill_d;
    end else begin : g_ctl_s2
      assign lvl_sel  = s1_amt_q[gi];
      assign lvl_rot  = s1_rot_q;
      assign lvl_fill = s1_fill_q;
    end
    assign chain[gi+1] = !lvl_sel ? lvl_src :
                         lvl_rot  ? {lvl_src[S-1:0], lvl_src[WIDTH-1:S]} :
                                    {{S{lvl_fill}}, lvl_src[WIDTH-1:S]};
  end

  assign s2_result = s1_rev_q ? out_rev : chain[LOG];

  assign s2_free    = !s2_valid_q || bus.out_ready;
  assign in_ready   = !s1_valid_q || s2_free;
  assign in_fire    = bus.in_valid && in_ready;
  assign s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
  assign s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_data_q    <= '0;
      out_carry_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s2_free && s1_valid_q) begin
        out_data_q    <= s2_result;
        out_carry_q   <= s1_carry_q;
        out_illegal_q <= s1_illegal_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_data_q    <= chain[LO];
      s1_amt_q     <= amt_d[LOG-1:LO];
      s1_rev_q     <= rev_d;
      s1_rot_q     <= rot_d;
      s1_fill_q    <= fill_d;
      s1_carry_q   <= carry_d;
      s1_illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_carry   = out_carry_q;
  assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised and directed bench for pipelined_barrel_shifter (WIDTH=32, AMT_W=8).
module tb_pipelined_barrel_shifter;
  localparam int W  = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus ();
  pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors    = 0;
  int miscompares = 0;
  logic [33:0] exp_q [$];

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  n;
    logic [2:0]  op;
    logic        c;
    logic [31:0] ed;
    logic        ec;
    logic        ei;
  } vec_t;

  // Returns {illegal, carry, data} straight from the ARM shift rules.
  function automatic logic [33:0] ref_model(input logic [31:0] d, input logic [7:0] n,
                                            input logic [2:0] op, input logic c);
    logic [31:0] r;
    logic        co, il;
    int          ni, m;
    r = d; co = c; il = 1'b0; ni = int'(n);
    case (op)
      3'd0: if (ni != 0) begin
        if (ni < 32)       begin r = d << ni; co = d[32-ni]; end
        else if (ni == 32) begin r = '0; co = d[0]; end
        else               begin r = '0; co = 1'b0; end
      end
      3'd1: if (ni != 0) begin
        if (ni < 32)       begin r = d >> ni; co = d[ni-1]; end
        else if (ni == 32) begin r = '0; co = d[31]; end
        else               begin r = '0; co = 1'b0; end
      end
      3'd2: if (ni != 0) begin
        if (ni < 32) begin r = 32'($signed(d) >>> ni); co = d[ni-1]; end
        else         begin r = {32{d[31]}}; co = d[31]; end
      end
      3'd3: if (ni != 0) begin
        m = ni % 32;
        if (m != 0) begin r = (d >> m) | (d << (32 - m)); co = d[m-1]; end
        else        co = d[31];
      end
      3'd4: begin r = {c, d[31:1]}; co = d[0]; end
      default: il = 1'b1;
    endcase
    return {il, co, r};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] n,
                       input logic [2:0] op, input logic c, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_amt    = n;
    bus.in_op     = op;
    bus.in_carry  = c;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_carry, bus.out_illegal, bus.in_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ctrl got v/c/i/rdy=%b want 0001",
               {bus.out_valid, bus.out_carry, bus.out_illegal, bus.in_ready});
    end
    vectors++;
    if (bus.out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 00000000", bus.out_data);
    end
  endtask

  task automatic test_directed();
    vec_t t [12];
    t[0]  = '{32'h8000_0001, 8'd1,  3'd0, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
    t[1]  = '{32'h8000_0000, 8'd32, 3'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    t[2]  = '{32'h8000_0000, 8'd33, 3'd1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    t[3]  = '{32'h8000_0000, 8'd40, 3'd2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    t[4]  = '{32'h0000_00F1, 8'd4,  3'd3, 1'b1, 32'h1000_000F, 1'b0, 1'b0};
    t[5]  = '{32'h0000_00F1, 8'd64, 3'd3, 1'b1, 32'h0000_00F1, 1'b0, 1'b0};
    t[6]  = '{32'h0000_00F1, 8'd0,  3'd3, 1'b1, 32'h0000_00F1, 1'b1, 1'b0};
    t[7]  = '{32'h0000_0003, 8'd9,  3'd4, 1'b1, 32'h8000_0001, 1'b1, 1'b0};
    t[8]  = '{32'h1234_5678, 8'd5,  3'd7, 1'b0, 32'h1234_5678, 1'b0, 1'b1};
    t[9]  = '{32'h0000_0001, 8'd32, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    t[10] = '{32'hDEAD_BEEF, 8'd0,  3'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0};
    t[11] = '{32'h8000_0010, 8'd4,  3'd2, 1'b1, 32'hF800_0001, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, t[i].d, t[i].n, t[i].op, t[i].c, 1'b1);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_in_ready got %b want 1", i, bus.in_ready);
      end
      drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL dir%0d_early got out_valid=%b want 0", i, bus.out_valid);
      end
      drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
      vectors++;
      if ({bus.out_valid, bus.out_illegal, bus.out_carry, bus.out_data} !==
          {1'b1, t[i].ei, t[i].ec, t[i].ed}) begin
        miscompares++;
        $display("FAIL dir%0d_result got v=%b i=%b c=%b d=%h want v=1 i=%b c=%b d=%h", i,
                 bus.out_valid, bus.out_illegal, bus.out_carry, bus.out_data,
                 t[i].ei, t[i].ec, t[i].ed);
      end
    end
    drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dir_drained got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [33:0] cur, prev_out, exp;
    logic        prev_stall;
    logic [31:0] d;
    logic [7:0]  n;
    logic [2:0]  op;
    logic        c;
    prev_stall = 1'b0;
    prev_out   = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 460; cyc++) begin
      d  = $urandom;
      n  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 66));
      op = 3'($urandom_range(0, 7));
      c  = 1'($urandom_range(0, 1));
      if (cyc < 400)
        drive($urandom_range(0, 3) != 0, d, n, op, c, $urandom_range(0, 3) != 0);
      else
        drive(1'b0, d, n, op, c, 1'b1);
      cur = {bus.out_illegal, bus.out_carry, bus.out_data};
      if (prev_stall) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || cur !== prev_out) begin
          miscompares++;
          $display("FAIL rnd_stall_hold cyc%0d got v=%b %h want v=1 %h", cyc, bus.out_valid, cur, prev_out);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious cyc%0d got %h want no result", cyc, cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            miscompares++;
            $display("FAIL rnd_result cyc%0d got %h want %h", cyc, cur, exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_model(d, n, op, c));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = cur;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_lost got %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] cur, prev_out, exp;
    logic        prev_stall, saw_block;
    logic [31:0] d;
    logic [7:0]  n;
    logic [2:0]  op;
    int          sent, recv, max_pipe;
    sent = 0; recv = 0; max_pipe = 0;
    prev_stall = 1'b0; saw_block = 1'b0; prev_out = '0;
    exp_q.delete();
    for (int k = 0; k < 40 && recv < 8; k++) begin
      d  = $urandom;
      n  = 8'($urandom_range(0, 40));
      op = 3'($urandom_range(0, 4));
      drive(sent < 8, d, n, op, 1'b1, !(k >= 3 && k < 8));
      cur = {bus.out_illegal, bus.out_carry, bus.out_data};
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || cur !== prev_out) begin
          miscompares++;
          $display("FAIL b2b_stall_hold k%0d got v=%b %h want v=1 %h", k, bus.out_valid, cur, prev_out);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        recv++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
        if (cur !== exp) begin
          miscompares++;
          $display("FAIL b2b_result%0d got %h want %h", recv, cur, exp);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_model(d, n, op, 1'b1));
        sent++;
      end
      if (exp_q.size() > max_pipe) max_pipe = exp_q.size();
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = cur;
    end
    vectors++;
    if (recv != 8 || sent != 8) begin
      miscompares++;
      $display("FAIL b2b_count got sent=%0d recv=%0d want 8/8", sent, recv);
    end
    vectors++;
    if (max_pipe != 2 || !saw_block) begin
      miscompares++;
      $display("FAIL b2b_buffering got depth=%0d blocked=%b want 2/1", max_pipe, saw_block);
    end
  endtask

  task automatic test_reset_flush();
    logic seen;
    seen = 1'b0;
    exp_q.delete();
    drive(1'b1, 32'h0000_00AA, 8'd1, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_00BB, 8'd2, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL flush_full got v/rdy=%b want 10", {bus.out_valid, bus.in_ready});
    end
    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_after got v/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1);
      if (bus.out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stale got out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
